// File: rtl/cmd_phy_multi_if.sv
// Bundle of the command-side handshake and the CMD pad signals of the SD
// command-line PHY. The slave side is the PHY. The master side is the
// command logic together with the card pad.
interface cmd_phy_multi_if;
    logic         new_cmd;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   resp_type;
    logic         cmd_from_sd;
    logic         cmd_to_sd;
    logic         cmd_to_sd_oe;
    logic         ready;
    logic         done;
    logic [127:0] resp_data;
    logic [5:0]   resp_index;
    logic         timeout_error;
    logic         crc_error;
    logic         index_error;
    logic         end_bit_error;

    modport master (
        output new_cmd, cmd_index, cmd_arg, resp_type, cmd_from_sd,
        input  cmd_to_sd, cmd_to_sd_oe, ready, done, resp_data, resp_index,
               timeout_error, crc_error, index_error, end_bit_error
    );

    modport slave (
        input  new_cmd, cmd_index, cmd_arg, resp_type, cmd_from_sd,
        output cmd_to_sd, cmd_to_sd_oe, ready, done, resp_data, resp_index,
               timeout_error, crc_error, index_error, end_bit_error
    );
endinterface

// File: rtl/cmd_phy_multi.sv
// SD CMD-line PHY. It sends a 48-bit command with CRC7, then optionally
// receives a 48-bit or 136-bit response. The response is checked for its
// end bit, its CRC7 and its index. A timeout applies while waiting for the
// response, and a fixed idle gap follows every transaction.
module cmd_phy_multi #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int NCC_CYCLES     = 8,
    parameter bit CHECK_INDEX    = 1'b1
) (
    input logic            CLK_SD_card,
    input logic            reset,
    cmd_phy_multi_if.slave bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_RECV = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    localparam logic [1:0] RT_NONE  = 2'b00;
    localparam logic [1:0] RT_SHORT = 2'b01;
    localparam logic [1:0] RT_LONG  = 2'b10;

    localparam int MAX_TG  = (TIMEOUT_CYCLES > NCC_CYCLES) ? TIMEOUT_CYCLES : NCC_CYCLES;
    localparam int CNT_MAX = (MAX_TG > 136) ? MAX_TG : 136;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(47);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(NCC_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(47);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(135);

    // CRC7 (x^7 + x^3 + 1, initial value 0) over a 120-bit window. Because
    // the initial value is zero, leading zero bits do not change the result.
    // Shorter messages are therefore zero-extended on the left.
    function automatic logic [6:0] crc7(input logic [119:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 119; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
        end
        return crc;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [47:0]      tx_q, tx_d;
    // Only the last 127 received bits are kept. Together with the bit on the
    // line, they cover frame bits 127:0, which are all the bits ever used.
    logic [126:0]     rx_q, rx_d;
    logic [5:0]       idx_q, idx_d;
    logic [1:0]       rtype_q, rtype_d;
    logic             done_q, done_d;
    logic [127:0]     resp_data_q, resp_data_d;
    logic [5:0]       resp_index_q, resp_index_d;
    logic             timeout_q, timeout_d;
    logic             crc_err_q, crc_err_d;
    logic             index_err_q, index_err_d;
    logic             end_err_q, end_err_d;

    logic [47:0]  frame48;
    logic [127:0] frame_long;
    logic [6:0]   cmd_crc;
    logic [6:0]   short_crc;
    logic [6:0]   long_crc;

    assign frame48    = {rx_q[46:0], bus.cmd_from_sd};
    assign frame_long = {rx_q[126:0], bus.cmd_from_sd};
    assign cmd_crc    = crc7({80'd0, 2'b01, bus.cmd_index, bus.cmd_arg});
    assign short_crc  = crc7({80'd0, frame48[47:8]});
    assign long_crc   = crc7(frame_long[127:8]);

    // Transaction sequencing: accept, serialise, await start bit, deserialise, gap
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        idx_d        = idx_q;
        rtype_d      = rtype_q;
        done_d       = 1'b0;
        resp_data_d  = resp_data_q;
        resp_index_d = resp_index_q;
        timeout_d    = timeout_q;
        crc_err_d    = crc_err_q;
        index_err_d  = index_err_q;
        end_err_d    = end_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.new_cmd) begin
                    state_d      = ST_SEND;
                    cnt_d        = '0;
                    tx_d         = {2'b01, bus.cmd_index, bus.cmd_arg, cmd_crc, 1'b1};
                    idx_d        = bus.cmd_index;
                    rtype_d      = bus.resp_type;
                    resp_data_d  = '0;
                    resp_index_d = '0;
                    timeout_d    = 1'b0;
                    crc_err_d    = 1'b0;
                    index_err_d  = 1'b0;
                    end_err_d    = 1'b0;
                end
            end
            ST_SEND: begin
                tx_d  = {tx_q[46:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SEND_LAST) begin
                    cnt_d = '0;
                    if (rtype_q == RT_NONE) begin
                        state_d = ST_GAP;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!bus.cmd_from_sd) begin
                    // The start bit counts as the first received bit.
                    state_d = ST_RECV;
                    cnt_d   = CNT_W'(1);
                    rx_d    = {rx_q[125:0], 1'b0};
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ST_GAP;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_RECV: begin
                rx_d  = {rx_q[125:0], bus.cmd_from_sd};
                cnt_d = cnt_q + 1'b1;
                if (rtype_q == RT_LONG) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d      = ST_GAP;
                        cnt_d        = '0;
                        done_d       = 1'b1;
                        resp_data_d  = frame_long;
                        resp_index_d = '0;
                        crc_err_d    = (long_crc != frame_long[7:1]);
                        end_err_d    = ~frame_long[0];
                    end
                end else if (cnt_q == SHORT_LAST) begin
                    state_d      = ST_GAP;
                    cnt_d        = '0;
                    done_d       = 1'b1;
                    resp_data_d  = {96'd0, frame48[39:8]};
                    resp_index_d = frame48[45:40];
                    crc_err_d    = (rtype_q == RT_SHORT) && (short_crc != frame48[7:1]);
                    index_err_d  = CHECK_INDEX && (rtype_q == RT_SHORT) &&
                                   (frame48[45:40] != idx_q);
                    end_err_d    = ~frame48[0];
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, shift registers and result registers; reset aborts any frame
    always_ff @(posedge CLK_SD_card or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            idx_q        <= '0;
            rtype_q      <= '0;
            done_q       <= 1'b0;
            resp_data_q  <= '0;
            resp_index_q <= '0;
            timeout_q    <= 1'b0;
            crc_err_q    <= 1'b0;
            index_err_q  <= 1'b0;
            end_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            idx_q        <= idx_d;
            rtype_q      <= rtype_d;
            done_q       <= done_d;
            resp_data_q  <= resp_data_d;
            resp_index_q <= resp_index_d;
            timeout_q    <= timeout_d;
            crc_err_q    <= crc_err_d;
            index_err_q  <= index_err_d;
            end_err_q    <= end_err_d;
        end
    end

    assign bus.cmd_to_sd_oe  = (state_q == ST_SEND);
    assign bus.cmd_to_sd     = (state_q == ST_SEND) ? tx_q[47] : 1'b1;
    assign bus.ready         = (state_q == ST_IDLE);
    assign bus.done          = done_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_index    = resp_index_q;
    assign bus.timeout_error = timeout_q;
    assign bus.crc_error     = crc_err_q;
    assign bus.index_error   = index_err_q;
    assign bus.end_bit_error = end_err_q;
endmodule

// File: tb/tb_cmd_phy_multi.sv
// Testbench for cmd_phy_multi. Each accepted command pushes its expected
// outcome onto a queue. The monitor pops one entry on every done pulse.
module tb_cmd_phy_multi;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_phy_multi_if bus ();

    cmd_phy_multi #(
        .TIMEOUT_CYCLES(64),
        .NCC_CYCLES    (8),
        .CHECK_INDEX   (1'b1)
    ) dut (
        .CLK_SD_card(clk),
        .reset      (rst_n),
        .bus        (bus)
    );

    typedef struct {
        logic [127:0] data;
        logic [5:0]   idx;
        logic [3:0]   flags;   // {timeout, crc, index, end_bit}
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [6:0] tb_crc(input logic [135:0] v, input int n);
        logic [6:0] c;
        c = 7'd0;
        for (int i = n - 1; i >= 0; i--)
            c = ((c << 1) & 7'h7F) ^ (((v[i] ^ c[6]) == 1'b1) ? 7'h09 : 7'h00);
        return c;
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, tb_crc({96'd0, 2'b01, idx, arg}, 40), 1'b1};
    endfunction

    // Response checker: compares the outputs against the oldest expectation on every done pulse.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected at cyc=%0d got done=1 want none", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle got %0d want %0d", cyc, mon_e.cyc);
                end
                checks++;
                if (bus.resp_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL resp_data got %h want %h", bus.resp_data, mon_e.data);
                end
                checks++;
                if (bus.resp_index !== mon_e.idx) begin
                    errors++;
                    $display("FAIL resp_index got %0d want %0d", bus.resp_index, mon_e.idx);
                end
                checks++;
                if ({bus.timeout_error, bus.crc_error, bus.index_error, bus.end_bit_error} !== mon_e.flags) begin
                    errors++;
                    $display("FAIL flags(to,crc,idx,end) got %b want %b",
                             {bus.timeout_error, bus.crc_error, bus.index_error, bus.end_bit_error},
                             mon_e.flags);
                end
            end
        end
    end

    // Presents a one-cycle strobe in cycle N. Returns at the negedge of cycle N+1.
    task automatic drive_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [1:0] rt, output int n);
        @(negedge clk);
        bus.new_cmd   = 1'b1;
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.resp_type = rt;
        n = cyc;
        @(negedge clk);
        bus.new_cmd = 1'b0;
    endtask

    // Samples 48 line bits, starting at the current negedge.
    task automatic capture_frame(output logic [47:0] f, output bit oe_ok);
        f = '0;
        oe_ok = 1'b1;
        for (int j = 0; j < 48; j++) begin
            if (j != 0) @(negedge clk);
            f = {f[46:0], bus.cmd_to_sd};
            if (bus.cmd_to_sd_oe !== 1'b1) oe_ok = 1'b0;
        end
    endtask

    // Card side: drives idle-high cycles, then the frame MSB first. Ends one cycle after the last bit.
    task automatic drive_resp(input logic [135:0] fr, input int len, input int delay);
        for (int d = 0; d < delay; d++) begin
            bus.cmd_from_sd = 1'b1;
            @(negedge clk);
        end
        for (int i = len - 1; i >= 0; i--) begin
            bus.cmd_from_sd = fr[i];
            @(negedge clk);
        end
        bus.cmd_from_sd = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ready, bus.cmd_to_sd_oe, bus.cmd_to_sd, bus.done} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/oe/cmd/done=%b want 1010",
                     {bus.ready, bus.cmd_to_sd_oe, bus.cmd_to_sd, bus.done});
        end
        checks++;
        if ({bus.resp_data, bus.resp_index, bus.timeout_error, bus.crc_error,
             bus.index_error, bus.end_bit_error} !== '0) begin
            errors++;
            $display("FAIL reset_results got data=%h idx=%0d flags nonzero or X", bus.resp_data, bus.resp_index);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cmd0;
        int n; logic [47:0] f; bit ok;
        drive_cmd(6'd0, 32'd0, 2'b00, n);
        sb.push_back('{128'd0, 6'd0, 4'b0000, n + 49});
        capture_frame(f, ok);
        checks++;
        if (f !== 48'h400000000095 || !ok) begin
            errors++;
            $display("FAIL cmd0_frame got %h oe_ok=%0d want 400000000095 oe_ok=1", f, ok);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0 || bus.cmd_to_sd_oe !== 1'b0) begin
            errors++;
            $display("FAIL cmd0_gap got ready=%b oe=%b want 0 0", bus.ready, bus.cmd_to_sd_oe);
        end
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd0_ready_return got %b want 1", bus.ready);
        end
    endtask

    // Sends a short-response command. The card answers after delay idle cycles.
    task automatic run_short(input string name, input logic [5:0] idx, input logic [31:0] arg,
                             input logic [1:0] rt, input logic [47:0] resp, input int delay,
                             input logic [31:0] e_data, input logic [5:0] e_idx, input logic [3:0] e_flags);
        int n; logic [47:0] f; bit ok;
        drive_cmd(idx, arg, rt, n);
        sb.push_back('{{96'd0, e_data}, e_idx, e_flags, n + 49 + delay + 48});
        capture_frame(f, ok);
        checks++;
        if (f !== cmd_frame(idx, arg) || !ok) begin
            errors++;
            $display("FAIL %s_cmd_frame got %h want %h", name, f, cmd_frame(idx, arg));
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_to_sd_oe !== 1'b0 || bus.cmd_to_sd !== 1'b1) begin
            errors++;
            $display("FAIL %s_release got oe=%b cmd=%b want 0 1", name, bus.cmd_to_sd_oe, bus.cmd_to_sd);
        end
        drive_resp({88'd0, resp}, 48, delay);
        repeat (8) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got %b want 1", name, bus.ready);
        end
    endtask

    task automatic test_cmd8;
        int n; logic [47:0] f; bit ok;
        drive_cmd(6'd8, 32'h1AA, 2'b01, n);
        sb.push_back('{128'h1AA, 6'd8, 4'b0000, n + 49 + 3 + 48});
        capture_frame(f, ok);
        checks++;
        if (f !== 48'h48000001AA87) begin
            errors++;
            $display("FAIL cmd8_frame got %h want 48000001aa87", f);
        end
        @(negedge clk);
        drive_resp({88'd0, 48'h08000001AA13}, 48, 3);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_short_errors;
        logic [47:0] r;
        r = {2'b00, 6'd9, 32'h1AA, tb_crc({96'd0, 2'b00, 6'd9, 32'h1AA}, 40), 1'b1};
        run_short("index_err", 6'd8, 32'h1AA, 2'b01, r, 0, 32'h1AA, 6'd9, 4'b0010);
        r = 48'h08000001AA13 ^ (48'h1 << 8);
        run_short("crc_err", 6'd8, 32'h1AA, 2'b01, r, 2, 32'h1AB, 6'd8, 4'b0100);
        run_short("end_bit_err", 6'd8, 32'h1AA, 2'b01, 48'h08000001AA12, 1, 32'h1AA, 6'd8, 4'b0001);
    endtask

    task automatic test_timeout;
        int n; logic [47:0] f; bit ok;
        bus.cmd_from_sd = 1'b1;
        drive_cmd(6'd17, 32'h100, 2'b01, n);
        sb.push_back('{128'd0, 6'd0, 4'b1000, n + 49 + 64});
        capture_frame(f, ok);
        repeat (64 + 8) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_gap got ready=%b want 0", bus.ready);
        end
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready_return got %b want 1", bus.ready);
        end
    endtask

    task automatic test_long;
        int n; logic [47:0] f; bit ok;
        logic [119:0] cid;
        logic [6:0]   c;
        logic [135:0] fr;
        cid = 120'h035344534430343880123456780142;
        c   = tb_crc({16'd0, cid}, 120);
        fr  = {2'b00, 6'h3F, cid, c, 1'b1};
        drive_cmd(6'd2, 32'd0, 2'b10, n);
        sb.push_back('{{cid, c, 1'b1}, 6'd0, 4'b0000, n + 49 + 5 + 136});
        capture_frame(f, ok);
        @(negedge clk);
        drive_resp(fr, 136, 5);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_r3;
        logic [47:0] r;
        r = {2'b00, 6'h3F, 32'h80FF8000, ~tb_crc({96'd0, 2'b00, 6'h3F, 32'h80FF8000}, 40), 1'b1};
        run_short("r3", 6'd41, 32'h40FF8000, 2'b11, r, 4, 32'h80FF8000, 6'h3F, 4'b0000);
    endtask

    task automatic test_reset_midframe;
        int n;
        drive_cmd(6'd8, 32'h1AA, 2'b01, n);
        repeat (19) @(negedge clk);
        checks++;
        if (bus.cmd_to_sd_oe !== 1'b1) begin
            errors++;
            $display("FAIL midframe_oe got %b want 1", bus.cmd_to_sd_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cmd_to_sd_oe !== 1'b0 || bus.cmd_to_sd !== 1'b1) begin
            errors++;
            $display("FAIL async_abort got oe=%b cmd=%b want 0 1", bus.cmd_to_sd_oe, bus.cmd_to_sd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.cmd_to_sd_oe !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got ready=%b oe=%b want 1 0", bus.ready, bus.cmd_to_sd_oe);
        end
    endtask

    // A command is held high through the whole transaction. It must be ignored while busy
    // and accepted in the cycle ready returns.
    task automatic test_busy_b2b;
        int n; logic [47:0] f; bit ok;
        drive_cmd(6'd0, 32'd0, 2'b00, n);
        sb.push_back('{128'd0, 6'd0, 4'b0000, n + 49});
        bus.new_cmd   = 1'b1;
        bus.cmd_index = 6'd5;
        bus.cmd_arg   = 32'h55;
        bus.resp_type = 2'b00;
        sb.push_back('{128'd0, 6'd0, 4'b0000, n + 57 + 49});
        capture_frame(f, ok);
        checks++;
        if (f !== 48'h400000000095 || !ok) begin
            errors++;
            $display("FAIL busy_frame got %h want 400000000095", f);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %b want 1", bus.ready);
        end
        @(negedge clk);
        bus.new_cmd = 1'b0;
        capture_frame(f, ok);
        checks++;
        if (f !== cmd_frame(6'd5, 32'h55) || !ok) begin
            errors++;
            $display("FAIL b2b_frame got %h want %h", f, cmd_frame(6'd5, 32'h55));
        end
        repeat (9) @(negedge clk);
    endtask

    initial begin
        bus.new_cmd     = 1'b0;
        bus.cmd_index   = '0;
        bus.cmd_arg     = '0;
        bus.resp_type   = '0;
        bus.cmd_from_sd = 1'b1;
        test_reset();
        test_cmd0();
        test_cmd8();
        test_short_errors();
        test_timeout();
        test_long();
        test_r3();
        test_reset_midframe();
        test_busy_b2b();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_done got %0d outstanding want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
